// File: rtl/mem_wb_skid_pkg.sv
// Shared constants and helpers for the MEM/WB skid buffer slice.
// Zero word, enable levels and the entry load-select encoding live here.
package mem_wb_skid_pkg;

   localparam int MAX_XLEN = 64;
   localparam logic [MAX_XLEN-1:0] ZERO_WORD = {MAX_XLEN{1'b0}};
   localparam logic EN  = 1'b1;
   localparam logic DIS = 1'b0;

   typedef enum logic [1:0] {
      LD_HOLD = 2'd0,
      LD_NEW  = 2'd1,
      LD_SKID = 2'd2,
      LD_CLR  = 2'd3
   } load_sel_e;

   // Register x0 is hard-wired to zero, so its write enable is dropped at accept time.
   function automatic logic wena_guard(input logic wena, input logic addr_nonzero);
      return wena & addr_nonzero;
   endfunction

endpackage

// File: rtl/mem_wb_skid_entry.sv
// One writeback entry: data, destination, write enable and valid flag.
// Clear wins over load so a flush never leaves stale contents behind.
module wb_entry_reg
   import mem_wb_skid_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               load,
   input  logic [XLEN-1:0]    load_data,
   input  logic [RADDR_W-1:0] load_addr,
   input  logic               load_wena,
   output logic [XLEN-1:0]    data,
   output logic [RADDR_W-1:0] addr,
   output logic               wena,
   output logic               valid
);

   // Entry storage with reset, clear and load.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         data  <= ZERO_WORD[XLEN-1:0];
         addr  <= {RADDR_W{1'b0}};
         wena  <= DIS;
         valid <= DIS;
      end else if (load) begin
         data  <= load_data;
         addr  <= load_addr;
         wena  <= load_wena;
         valid <= EN;
      end else begin
         data  <= data;
         addr  <= addr;
         wena  <= wena;
         valid <= valid;
      end
   end

endmodule

// File: rtl/mem_wb_skid.sv
// Two-entry MEM/WB skid buffer with registered in_ready, bypass lookup
// and a saturating back-pressure counter.
module mem_wb_skid
   import mem_wb_skid_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [XLEN-1:0]    in_mem_data,
   input  logic [XLEN-1:0]    in_alu_result,
   input  logic               in_mem2reg,
   input  logic [RADDR_W-1:0] in_reg_waddr,
   input  logic               in_reg_wena,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_wb_data,
   output logic [RADDR_W-1:0] out_reg_waddr,
   output logic               out_reg_wena,
   input  logic [RADDR_W-1:0] fwd_raddr,
   output logic               fwd_hit,
   output logic [XLEN-1:0]    fwd_data,
   output logic [CNT_W-1:0]   stall_cnt
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0]         state_r;
   logic [1:0]         state_nxt_s;
   logic               in_ready_r;
   logic [CNT_W-1:0]   stall_cnt_r;

   logic               accept_s;
   logic               retire_s;
   logic [XLEN-1:0]    new_data_s;
   logic               new_wena_s;
   load_sel_e          main_sel_s;
   load_sel_e          skid_sel_s;

   logic [XLEN-1:0]    main_load_data_s;
   logic [RADDR_W-1:0] main_load_addr_s;
   logic               main_load_wena_s;

   logic [XLEN-1:0]    main_data_s;
   logic [RADDR_W-1:0] main_addr_s;
   logic               main_wena_s;
   logic               main_valid_s;
   logic [XLEN-1:0]    skid_data_s;
   logic [RADDR_W-1:0] skid_addr_s;
   logic               skid_wena_s;
   logic               skid_valid_s;

   logic               hit_main_s;
   logic               hit_skid_s;

   assign accept_s   = in_valid & in_ready_r;
   assign retire_s   = out_valid & out_ready;
   assign new_data_s = in_mem2reg ? in_mem_data : in_alu_result;
   assign new_wena_s = wena_guard(in_reg_wena, (in_reg_waddr != {RADDR_W{1'b0}}));

   // Occupancy control: flush overrides any handshake in the same cycle.
   always_comb begin
      state_nxt_s = state_r;
      main_sel_s  = LD_HOLD;
      skid_sel_s  = LD_HOLD;
      if (flush) begin
         state_nxt_s = ST_EMPTY;
         main_sel_s  = LD_CLR;
         skid_sel_s  = LD_CLR;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) begin
                  state_nxt_s = ST_ONE;
                  main_sel_s  = LD_NEW;
               end else begin
                  state_nxt_s = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (accept_s && retire_s) begin
                  main_sel_s = LD_NEW;
               end else if (accept_s) begin
                  state_nxt_s = ST_TWO;
                  skid_sel_s  = LD_NEW;
               end else if (retire_s) begin
                  state_nxt_s = ST_EMPTY;
                  main_sel_s  = LD_CLR;
               end else begin
                  state_nxt_s = ST_ONE;
               end
            end
            ST_TWO: begin
               if (retire_s) begin
                  state_nxt_s = ST_ONE;
                  main_sel_s  = LD_SKID;
                  skid_sel_s  = LD_CLR;
               end else begin
                  state_nxt_s = ST_TWO;
               end
            end
            default: begin
               state_nxt_s = ST_EMPTY;
               main_sel_s  = LD_CLR;
               skid_sel_s  = LD_CLR;
            end
         endcase
      end
   end

   // The head refills either from the incoming entry or from the skid slot.
   always_comb begin
      main_load_data_s = new_data_s;
      main_load_addr_s = in_reg_waddr;
      main_load_wena_s = new_wena_s;
      if (main_sel_s == LD_SKID) begin
         main_load_data_s = skid_data_s;
         main_load_addr_s = skid_addr_s;
         main_load_wena_s = skid_wena_s;
      end else begin
         main_load_data_s = new_data_s;
         main_load_addr_s = in_reg_waddr;
         main_load_wena_s = new_wena_s;
      end
   end

   wb_entry_reg #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_main (
      .clk       (clk),
      .rst       (rst),
      .clr       (main_sel_s == LD_CLR),
      .load      ((main_sel_s == LD_NEW) || (main_sel_s == LD_SKID)),
      .load_data (main_load_data_s),
      .load_addr (main_load_addr_s),
      .load_wena (main_load_wena_s),
      .data      (main_data_s),
      .addr      (main_addr_s),
      .wena      (main_wena_s),
      .valid     (main_valid_s)
   );

   wb_entry_reg #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .clr       (skid_sel_s == LD_CLR),
      .load      (skid_sel_s == LD_NEW),
      .load_data (new_data_s),
      .load_addr (in_reg_waddr),
      .load_wena (new_wena_s),
      .data      (skid_data_s),
      .addr      (skid_addr_s),
      .wena      (skid_wena_s),
      .valid     (skid_valid_s)
   );

   // State and in_ready are both registered; in_ready looks ahead at the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_EMPTY;
         in_ready_r <= EN;
      end else begin
         state_r    <= state_nxt_s;
         in_ready_r <= (state_nxt_s != ST_TWO);
      end
   end

   // Saturating count of cycles where the MEM stage was held off.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (in_valid && !in_ready_r && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign in_ready      = in_ready_r;
   assign stall_cnt     = stall_cnt_r;
   assign out_valid     = (state_r != ST_EMPTY);
   assign out_wb_data   = out_valid ? main_data_s : ZERO_WORD[XLEN-1:0];
   assign out_reg_waddr = out_valid ? main_addr_s : {RADDR_W{1'b0}};
   assign out_reg_wena  = out_valid ? main_wena_s : DIS;

   assign hit_main_s = main_valid_s & main_wena_s & (main_addr_s == fwd_raddr);
   assign hit_skid_s = skid_valid_s & skid_wena_s & (skid_addr_s == fwd_raddr);

   // Bypass: the skid entry is younger, so it wins over the head.
   always_comb begin
      fwd_hit  = DIS;
      fwd_data = ZERO_WORD[XLEN-1:0];
      if (fwd_raddr == {RADDR_W{1'b0}}) begin
         fwd_hit  = DIS;
         fwd_data = ZERO_WORD[XLEN-1:0];
      end else if (hit_skid_s) begin
         fwd_hit  = EN;
         fwd_data = skid_data_s;
      end else if (hit_main_s) begin
         fwd_hit  = EN;
         fwd_data = main_data_s;
      end else begin
         fwd_hit  = DIS;
         fwd_data = ZERO_WORD[XLEN-1:0];
      end
   end

endmodule

// File: tb/tb_mem_wb_skid.sv
// Directed bench for mem_wb_skid: reset, pass-through, back-pressure,
// load select / x0, forwarding, flush, saturation and mid-run reset.
module tb_mem_wb_skid;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, in_mem2reg, in_reg_wena;
   logic [31:0] in_mem_data, in_alu_result;
   logic [4:0]  in_reg_waddr;
   logic        out_valid, out_ready, out_reg_wena;
   logic [31:0] out_wb_data;
   logic [4:0]  out_reg_waddr;
   logic [4:0]  fwd_raddr;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic [2:0]  stall_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_wb_skid #(.XLEN(32), .RADDR_W(5), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mem_data(in_mem_data), .in_alu_result(in_alu_result),
      .in_mem2reg(in_mem2reg), .in_reg_waddr(in_reg_waddr), .in_reg_wena(in_reg_wena),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_wb_data(out_wb_data), .out_reg_waddr(out_reg_waddr), .out_reg_wena(out_reg_wena),
      .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .stall_cnt(stall_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] mem,
                        input logic m2r, input logic [4:0] wa, input logic we);
      in_valid = v; in_alu_result = alu; in_mem_data = mem;
      in_mem2reg = m2r; in_reg_waddr = wa; in_reg_wena = we;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0; fwd_raddr = 5'd0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      tick(); tick();
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (out_wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data got %h exp 0", out_wb_data); end
      checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
   endtask

   task automatic test_single_pass();
      out_ready = 1'b1;
      drive(1'b1, 32'h1234, 32'h9999, 1'b0, 5'd5, 1'b1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
      checks++; if (out_wb_data !== 32'h1234) begin errors++; $display("FAIL single_data got %h exp 1234", out_wb_data); end
      checks++; if (out_reg_waddr !== 5'd5 || out_reg_wena !== 1'b1) begin errors++; $display("FAIL single_addr got %0d/%b exp 5/1", out_reg_waddr, out_reg_wena); end
      tick();
      checks++; if (out_valid !== 1'b0 || out_wb_data !== 32'h0 || out_reg_waddr !== 5'd0) begin errors++; $display("FAIL single_empty got %b/%h/%0d exp 0/0/0", out_valid, out_wb_data, out_reg_waddr); end
   endtask

   task automatic test_back_pressure();
      out_ready = 1'b0;
      drive(1'b1, 32'hA, 32'h0, 1'b0, 5'd1, 1'b1);
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got %b exp 1", in_ready); end
      drive(1'b1, 32'hB, 32'h0, 1'b0, 5'd2, 1'b1);
      tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_two got %b exp 0", in_ready); end
      drive(1'b1, 32'hC, 32'h0, 1'b0, 5'd3, 1'b1);
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++; if (stall_cnt !== 3'(i)) begin errors++; $display("FAIL bp_stall got %0d exp %0d", stall_cnt, i); end
         checks++; if (out_wb_data !== 32'hA || out_reg_waddr !== 5'd1) begin errors++; $display("FAIL bp_hold got %h/%0d exp a/1", out_wb_data, out_reg_waddr); end
      end
      out_ready = 1'b1;
      tick();
      checks++; if (out_wb_data !== 32'hB || in_ready !== 1'b1 || stall_cnt !== 3'd4) begin errors++; $display("FAIL bp_second got %h/%b/%0d exp b/1/4", out_wb_data, in_ready, stall_cnt); end
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_wb_data !== 32'hC || out_reg_waddr !== 5'd3) begin errors++; $display("FAIL bp_third got %b/%h/%0d exp 1/c/3", out_valid, out_wb_data, out_reg_waddr); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
   endtask

   task automatic test_load_x0();
      out_ready = 1'b1;
      drive(1'b1, 32'h5555, 32'hDEAD, 1'b1, 5'd0, 1'b1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      checks++; if (out_wb_data !== 32'hDEAD) begin errors++; $display("FAIL load_data got %h exp dead", out_wb_data); end
      checks++; if (out_reg_wena !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL x0_wena got %b/%b exp 0/1", out_reg_wena, out_valid); end
      tick();
   endtask

   task automatic test_forward();
      out_ready = 1'b0;
      drive(1'b1, 32'h11, 32'h0, 1'b0, 5'd3, 1'b1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      fwd_raddr = 5'd3; #1;
      checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h11) begin errors++; $display("FAIL fwd_main got %b/%h exp 1/11", fwd_hit, fwd_data); end
      drive(1'b1, 32'h22, 32'h0, 1'b0, 5'd3, 1'b1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      #1;
      checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin errors++; $display("FAIL fwd_skid got %b/%h exp 1/22", fwd_hit, fwd_data); end
      fwd_raddr = 5'd0; #1;
      checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin errors++; $display("FAIL fwd_x0 got %b/%h exp 0/0", fwd_hit, fwd_data); end
      fwd_raddr = 5'd7; #1;
      checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_miss got %b exp 0", fwd_hit); end
   endtask

   task automatic test_flush();
      flush = 1'b1;
      drive(1'b1, 32'h77, 32'h0, 1'b0, 5'd4, 1'b1);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_wb_data !== 32'h0) begin errors++; $display("FAIL flush_state got %b/%b/%h exp 0/1/0", out_valid, in_ready, out_wb_data); end
      checks++; if (stall_cnt !== 3'd5) begin errors++; $display("FAIL flush_stall got %0d exp 5", stall_cnt); end
      fwd_raddr = 5'd3; #1;
      checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL flush_fwd3 got %b exp 0", fwd_hit); end
      fwd_raddr = 5'd4; #1;
      checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL flush_fwd4 got %b exp 0", fwd_hit); end
      out_ready = 1'b1;
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost got %b exp 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(1'b1, 32'h31, 32'h0, 1'b0, 5'd9, 1'b1);
      tick();
      drive(1'b1, 32'h32, 32'h0, 1'b0, 5'd10, 1'b1);
      tick();
      drive(1'b1, 32'h33, 32'h0, 1'b0, 5'd11, 1'b1);
      tick(); tick();
      checks++; if (stall_cnt !== 3'd7) begin errors++; $display("FAIL mid_stall7 got %0d exp 7", stall_cnt); end
      tick();
      checks++; if (stall_cnt !== 3'd7) begin errors++; $display("FAIL stall_saturate got %0d exp 7", stall_cnt); end
      rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
      tick();
      rst = 1'b0; flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      fwd_raddr = 5'd10; #1;
      checks++; if (out_valid !== 1'b0 || out_wb_data !== 32'h0 || out_reg_waddr !== 5'd0 || out_reg_wena !== 1'b0) begin errors++; $display("FAIL mid_rst_out got %b/%h/%0d/%b exp 0/0/0/0", out_valid, out_wb_data, out_reg_waddr, out_reg_wena); end
      checks++; if (stall_cnt !== 3'd0 || in_ready !== 1'b1 || fwd_hit !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl got %0d/%b/%b exp 0/1/0", stall_cnt, in_ready, fwd_hit); end
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_back_pressure();
      test_load_x0();
      test_forward();
      test_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
